// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array driver.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Skewed feed lasts until the last diagonal reaches the far corner PE.
  function automatic int feed_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

  function automatic int cnt_width(input int dim);
    return $clog2(3 * dim - 1);
  endfunction

  localparam int SA_DIM      = 8;
  localparam int FEED_CYCLES = feed_cycles(SA_DIM);
  localparam int CNT_W       = cnt_width(SA_DIM);

endpackage

// File: rtl/systolic_driver_operand_buf.sv
// DIM x DIM operand register file: one-row write port, combinational skewed edge read.
// ROWMAJ=1 presents out[k] = M[k][t-k] (A edge), ROWMAJ=0 presents out[k] = M[t-k][k] (B edge).
module operand_buf #(
  parameter int BITS   = 8,
  parameter int DIM    = 8,
  parameter int CW     = 5,
  parameter int RW     = $clog2(DIM),
  parameter bit ROWMAJ = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [RW-1:0]          wrow,
  input  logic signed [BITS-1:0] wdata [DIM-1:0],
  input  logic [CW-1:0]          t,
  output logic signed [BITS-1:0] skew  [DIM-1:0]
);

  logic signed [BITS-1:0] m    [DIM-1:0][DIM-1:0];
  logic [CW:0]            diff [DIM-1:0];

  // Row write; buffer contents cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++)
          m[i][j] <= '0;
    end else if (we) begin
      for (int j = 0; j < DIM; j++)
        m[wrow][j] <= wdata[j];
    end
  end

  // Diagonal read: lane k carries element t-k of its row/column, zero outside the matrix.
  always_comb begin
    for (int k = 0; k < DIM; k++) begin
      diff[k] = {1'b0, t} - (CW+1)'(k);
      skew[k] = '0;
      if (({1'b0, t} >= (CW+1)'(k)) && (diff[k] < (CW+1)'(DIM))) begin
        if (ROWMAJ)
          skew[k] = m[k][diff[k][RW-1:0]];
        else
          skew[k] = m[diff[k][RW-1:0]][k];
      end
    end
  end

endmodule

// File: rtl/systolic_driver.sv
// Drive side of the systolic MAC array: operand buffers, clear/feed/drain sequencing.
module systolic_driver
  import systolic_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int RW      = $clog2(DIM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic                      ld_selB,
  input  logic [RW-1:0]             ld_row,
  input  logic signed [BITS_AB-1:0] ld_data   [DIM-1:0],
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic signed [BITS_AB-1:0] sa_A      [DIM-1:0],
  output logic signed [BITS_AB-1:0] sa_B      [DIM-1:0],
  output logic signed [BITS_C-1:0]  sa_Cin    [DIM-1:0],
  output logic [RW-1:0]             sa_Crow,
  output logic                      sa_WrEn,
  output logic                      sa_en,
  input  logic signed [BITS_C-1:0]  sa_Cout   [DIM-1:0],
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [RW-1:0]             res_row,
  output logic signed [BITS_C-1:0]  res_data  [DIM-1:0]
);

  // state | meaning
  // IDLE  | accept operand row writes, wait for start
  // CLEAR | zero one accumulator row per cycle (DIM cycles)
  // FEED  | stream skewed A/B edges into the array (3*DIM-2 cycles)
  // DRAIN | present C rows one per valid/ready handshake
  localparam int CW = cnt_width(DIM);

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [RW-1:0]             r, r_nxt;
  logic                      done_nxt;
  logic                      wr_a, wr_b;
  logic signed [BITS_AB-1:0] a_edge [DIM-1:0];
  logic signed [BITS_AB-1:0] b_edge [DIM-1:0];

  assign wr_a = ld_valid && (state == IDLE) && !ld_selB;
  assign wr_b = ld_valid && (state == IDLE) &&  ld_selB;

  // Edges are read at the next-cycle index so the registered outputs line up with the state.
  operand_buf #(.BITS(BITS_AB), .DIM(DIM), .CW(CW), .RW(RW), .ROWMAJ(1'b1)) u_buf_a (
    .clk(clk), .rst(rst), .we(wr_a), .wrow(ld_row), .wdata(ld_data), .t(cnt_nxt), .skew(a_edge)
  );

  operand_buf #(.BITS(BITS_AB), .DIM(DIM), .CW(CW), .RW(RW), .ROWMAJ(1'b0)) u_buf_b (
    .clk(clk), .rst(rst), .we(wr_b), .wrow(ld_row), .wdata(ld_data), .t(cnt_nxt), .skew(b_edge)
  );

  // State, phase counter and drain row registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      r     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      r     <= r_nxt;
    end
  end

  // Next-state, counter and done decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    r_nxt     = r;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        r_nxt   = '0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (cnt == CW'(DIM-1)) begin
          state_nxt = FEED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FEED: begin
        if (cnt == CW'(3*DIM-3)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
          r_nxt     = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (r == RW'(DIM-1)) begin
            state_nxt = IDLE;
            r_nxt     = '0;
            done_nxt  = 1'b1;
          end else begin
            r_nxt = r + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, decoded from the upcoming state so they are valid for its whole duration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      sa_WrEn   <= 1'b0;
      sa_en     <= 1'b0;
      sa_Crow   <= '0;
      res_valid <= 1'b0;
      res_row   <= '0;
      for (int k = 0; k < DIM; k++) begin
        sa_A[k] <= '0;
        sa_B[k] <= '0;
      end
    end else begin
      ld_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
      sa_WrEn   <= (state_nxt == CLEAR);
      sa_en     <= (state_nxt == FEED);
      res_valid <= (state_nxt == DRAIN);
      res_row   <= (state_nxt == DRAIN) ? r_nxt : '0;
      if (state_nxt == CLEAR)
        sa_Crow <= cnt_nxt[RW-1:0];
      else if (state_nxt == DRAIN)
        sa_Crow <= r_nxt;
      else
        sa_Crow <= '0;
      for (int k = 0; k < DIM; k++) begin
        sa_A[k] <= (state_nxt == FEED) ? a_edge[k] : '0;
        sa_B[k] <= (state_nxt == FEED) ? b_edge[k] : '0;
      end
    end
  end

  // Clear value is always zero; results pass straight through from the array.
  always_comb begin
    for (int k = 0; k < DIM; k++) begin
      sa_Cin[k]   = '0;
      res_data[k] = sa_Cout[k];
    end
  end

endmodule

// File: tb/tb_systolic_driver.sv
// Driver plus a behavioural output-stationary systolic array, checked against C = A x B.
module tb_systolic_driver;

  localparam int DIM = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ld_valid, ld_ready, ld_selB;
  logic [2:0]              ld_row;
  logic signed [7:0]       ld_data  [DIM-1:0];
  logic                    start, busy, done;
  logic signed [7:0]       sa_A     [DIM-1:0];
  logic signed [7:0]       sa_B     [DIM-1:0];
  logic signed [15:0]      sa_Cin   [DIM-1:0];
  logic [2:0]              sa_Crow;
  logic                    sa_WrEn, sa_en;
  logic signed [15:0]      sa_Cout  [DIM-1:0];
  logic                    res_valid, res_ready;
  logic [2:0]              res_row;
  logic signed [15:0]      res_data [DIM-1:0];

  int n_checks = 0;
  int n_fail   = 0;
  int ma [DIM][DIM];
  int mb [DIM][DIM];

  always #5 clk = ~clk;

  systolic_driver #(.BITS_AB(8), .BITS_C(16), .DIM(DIM)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_selB(ld_selB), .ld_row(ld_row), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done),
    .sa_A(sa_A), .sa_B(sa_B), .sa_Cin(sa_Cin), .sa_Crow(sa_Crow), .sa_WrEn(sa_WrEn), .sa_en(sa_en),
    .sa_Cout(sa_Cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_data(res_data)
  );

  // Array environment: A moves right, B moves down, each PE accumulates a*b.
  logic signed [7:0]  a_reg [DIM][DIM];
  logic signed [7:0]  b_reg [DIM][DIM];
  logic signed [7:0]  a_in  [DIM][DIM];
  logic signed [7:0]  b_in  [DIM][DIM];
  logic signed [15:0] acc   [DIM][DIM];

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_in[i][0] = sa_A[i];
      for (int j = 1; j < DIM; j++) a_in[i][j] = a_reg[i][j-1];
    end
    for (int j = 0; j < DIM; j++) begin
      b_in[0][j] = sa_B[j];
      for (int i = 1; i < DIM; i++) b_in[i][j] = b_reg[i-1][j];
    end
    for (int j = 0; j < DIM; j++) sa_Cout[j] = acc[sa_Crow][j];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
    end else begin
      if (sa_WrEn)
        for (int j = 0; j < DIM; j++) acc[sa_Crow][j] <= sa_Cin[j];
      if (sa_en)
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) begin
            a_reg[i][j] <= a_in[i][j];
            b_reg[i][j] <= b_in[i][j];
            acc[i][j]   <= acc[i][j] + a_in[i][j] * b_in[i][j];
          end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input bit with_start);
    for (int sel = 0; sel < 2; sel++)
      for (int r = 0; r < DIM; r++) begin
        @(negedge clk);
        ld_valid = 1'b1;
        ld_selB  = (sel == 1);
        ld_row   = 3'(r);
        for (int k = 0; k < DIM; k++)
          ld_data[k] = (sel == 1) ? 8'(mb[r][k]) : 8'(ma[r][k]);
        if (with_start && sel == 1 && r == DIM-1) start = 1'b1;
      end
    @(negedge clk);
    ld_valid = 1'b0;
    start    = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1-0-0, 2: random ready.
  task automatic run(input int mode, input bit started, input int abort_at);
    int  exp_c [DIM][DIM];
    int  fcnt, row, dones, done_cyc, ferr, serr, stall_row, idx, ea, eb, s, rcnt;
    bit  stalled, rdy, aborted;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        s = 0;
        for (int k = 0; k < DIM; k++) s += ma[i][k] * mb[k][j];
        exp_c[i][j] = int'(shortint'(s));
      end
    if (!started) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    check_eq("busy_on_run", int'(busy), 1);
    fcnt = 0; row = 0; dones = 0; done_cyc = -1; ferr = 0; serr = 0;
    stall_row = 0; rcnt = 0; stalled = 1'b0; aborted = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 2) begin
        ld_valid = 1'b1; ld_selB = 1'b0; ld_row = 3'd0; start = 1'b1;
        for (int k = 0; k < DIM; k++) ld_data[k] = 8'sd55;
      end
      if (cyc == 3) begin
        ld_valid = 1'b0; start = 1'b0;
      end
      if (sa_en) begin
        for (int k = 0; k < DIM; k++) begin
          idx = fcnt - k;
          ea  = (idx >= 0 && idx < DIM) ? ma[k][idx] : 0;
          eb  = (idx >= 0 && idx < DIM) ? mb[idx][k] : 0;
          if (int'(sa_A[k]) != ea) ferr++;
          if (int'(sa_B[k]) != eb) ferr++;
        end
        if (fcnt == abort_at) begin
          aborted = 1'b1;
          break;
        end
        fcnt++;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check_eq("rows_before_done", row, DIM);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((rcnt % 3) == 0);
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      rcnt++;
      res_ready = rdy;
      if (res_valid) begin
        if (stalled && int'(res_row) != stall_row) serr++;
        if (rdy) begin
          check_eq("row_order", int'(res_row), row);
          if (row < DIM)
            for (int j = 0; j < DIM; j++)
              check_eq($sformatf("c[%0d][%0d]", row, j), int'(res_data[j]), exp_c[row][j]);
          row++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          stall_row = int'(res_row);
        end
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    if (aborted) begin
      check_eq("feed_edges_pre_rst", ferr, 0);
      rst = 1'b1;
      #1;
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_ld_ready", int'(ld_ready), 1);
      check_eq("rst_sa_en", int'(sa_en), 0);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      repeat (4) begin
        @(negedge clk);
        if (done) dones++;
      end
      check_eq("no_done_after_rst", dones, 0);
      check_eq("idle_after_rst", int'(busy), 0);
      return;
    end
    check_eq("done_seen", int'(done_cyc >= 0), 1);
    check_eq("done_pulses", dones, 1);
    check_eq("en_cycles", fcnt, 3*DIM-2);
    check_eq("feed_edges", ferr, 0);
    check_eq("stall_hold", serr, 0);
    check_eq("busy_end", int'(busy), 0);
    check_eq("ld_ready_end", int'(ld_ready), 1);
  endtask

  task automatic set_ident(input int scale, input bit to_b);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        if (to_b) mb[i][j] = (i == j) ? scale : 0;
        else      ma[i][j] = (i == j) ? scale : 0;
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_selB = 1'b0; ld_row = '0; start = 1'b0; res_ready = 1'b0;
    for (int k = 0; k < DIM; k++) ld_data[k] = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ld_ready", int'(ld_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_res_valid", int'(res_valid), 0);
    check_eq("rst_sa_en", int'(sa_en), 0);
    check_eq("rst_sa_wren", int'(sa_WrEn), 0);
    rst = 1'b0;

    // Identity times an index-valued matrix.
    set_ident(1, 1'b0);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) mb[i][j] = i * 8 + j;
    load(1'b0);
    run(0, 1'b0, -1);

    // Full-scale positive operands: result wraps in 16 bits.
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = 127;
        mb[i][j] = 127;
      end
    load(1'b0);
    run(0, 1'b0, -1);

    // All -1 times identity, then 2I without reset: accumulators must be cleared.
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) ma[i][j] = -1;
    set_ident(1, 1'b1);
    load(1'b0);
    run(0, 1'b0, -1);
    set_ident(2, 1'b1);
    load(1'b0);
    run(1, 1'b0, -1);

    // Random operands; the first run has start in the same cycle as the last write.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          ma[i][j] = int'($urandom_range(255, 0)) - 128;
          mb[i][j] = int'($urandom_range(255, 0)) - 128;
        end
      load(n == 0);
      run(n == 1 ? 1 : 2, n == 0, -1);
    end

    // Reset during feed: buffers come back zero, then a reload works.
    set_ident(1, 1'b0);
    set_ident(1, 1'b1);
    load(1'b0);
    run(0, 1'b0, 5);
    set_ident(0, 1'b0);
    set_ident(0, 1'b1);
    run(0, 1'b0, -1);
    set_ident(1, 1'b0);
    set_ident(1, 1'b1);
    load(1'b0);
    run(2, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
